obi_periph_demux: RTL and testbench

- Parametrised OBI 1-to-N demultiplexer. Routes one OBI initiator (the SoC unified bus) to NUM_TARGETS OBI targets, for example DRAM, IRAM, UART and the WB bridge.
- Decodes the target from a configurable address field.
- Keeps responses in order by tracking outstanding transactions.
- Answers unmapped addresses and hung targets with an error response, so the core never deadlocks.
- Replaces the hard-wired block_sel decode with its fixed one-cycle grant and rvalid rules.

---
 rtl/obi_pkg.sv | 25 ++
 rtl/obi_err_responder.sv | 30 +++
 rtl/obi_periph_demux.sv | 220 ++++++++++++++++++++++
 tb/tb_obi_periph_demux.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI peripheral demultiplexer.
package obi_pkg;

    // Demux control states: no traffic, transactions in flight, draining after a timeout.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } demux_state_e;

    // Data returned with every error response (unmapped access or timeout flush).
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // SoC region map: value of the address target-select field for each peripheral.
    localparam int REGION_DRAM = 0;
    localparam int REGION_IRAM = 1;
    localparam int REGION_UART = 2;
    localparam int REGION_WB   = 3;

    // Width of an internal target id; one extra id is reserved for the error responder.
    function automatic int tgt_id_width(input int num_targets);
        return $clog2(num_targets + 1);
    endfunction

endpackage

// File: rtl/obi_err_responder.sv
// Internal responder for unmapped addresses: answers each accepted access
// with an error response exactly one cycle after its grant.
module obi_err_responder
    import obi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = ERR_RDATA_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  accept_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic pending_r;

    // Remember an accepted unmapped access so it is answered on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= accept_i;
        end
    end

    assign rvalid_o = pending_r;
    assign rdata_o  = pending_r ? ERR_RDATA : {DATA_WIDTH{1'b0}};

endmodule

// File: rtl/obi_periph_demux.sv
// OBI 1-to-N demultiplexer: address-decoded routing to NUM_TARGETS targets,
// in-order responses, error replies for unmapped addresses and hung targets.
module obi_periph_demux
    import obi_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    NUM_TARGETS     = 4,
    parameter int                    SEL_LSB         = 20,
    parameter int                    SEL_WIDTH       = 2,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter int                    TIMEOUT_CYCLES  = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = ERR_RDATA_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              init_req_i,
    output logic                              init_gnt_o,
    input  logic [ADDR_WIDTH-1:0]             init_addr_i,
    input  logic                              init_we_i,
    input  logic [DATA_WIDTH/8-1:0]           init_be_i,
    input  logic [DATA_WIDTH-1:0]             init_wdata_i,
    output logic                              init_rvalid_o,
    output logic [DATA_WIDTH-1:0]             init_rdata_o,
    output logic                              init_err_o,
    output logic [NUM_TARGETS-1:0]            tgt_req_o,
    input  logic [NUM_TARGETS-1:0]            tgt_gnt_i,
    output logic [ADDR_WIDTH-1:0]             tgt_addr_o,
    output logic                              tgt_we_o,
    output logic [DATA_WIDTH/8-1:0]           tgt_be_o,
    output logic [DATA_WIDTH-1:0]             tgt_wdata_o,
    input  logic [NUM_TARGETS-1:0]            tgt_rvalid_i,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] tgt_rdata_i,
    output logic                              timeout_o
);

    localparam int ID_W  = tgt_id_width(NUM_TARGETS);
    localparam int CNT_W = 4;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [ID_W-1:0]  ERR_ID   = ID_W'(NUM_TARGETS);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    demux_state_e          state_r, state_nxt_s;
    logic [CNT_W-1:0]      count_r, count_nxt_s;
    logic [TMR_W-1:0]      timer_r, timer_nxt_s;
    logic [ID_W-1:0]       cur_id_r;

    logic [SEL_WIDTH-1:0]  sel_s;
    logic                  unmapped_s;
    logic [ID_W-1:0]       id_s;
    logic                  stall_s;
    logic                  accept_s;
    logic                  cur_is_err_s;
    logic                  sel_gnt_s;
    logic                  sel_rvalid_s;
    logic [DATA_WIDTH-1:0] sel_rdata_s;
    logic                  err_rvalid_s;
    logic [DATA_WIDTH-1:0] err_rdata_s;
    logic                  fwd_rsp_s;
    logic                  flush_rsp_s;
    logic                  timeout_s;

    // Request attributes go to every target; only tgt_req_o selects one.
    assign tgt_addr_o  = init_addr_i;
    assign tgt_we_o    = init_we_i;
    assign tgt_be_o    = init_be_i;
    assign tgt_wdata_o = init_wdata_i;

    // Decode: select values beyond the last target map to the error responder id.
    assign sel_s      = init_addr_i[SEL_LSB +: SEL_WIDTH];
    assign unmapped_s = (int'(sel_s) >= NUM_TARGETS);
    assign id_s       = unmapped_s ? ERR_ID : ID_W'(sel_s);

    // Only one target may have outstanding transactions, which keeps responses in order.
    assign stall_s = (state_r == FLUSH)
                   | (count_r == CNT_MAX)
                   | ((count_r != CNT_ZERO) & (id_s != cur_id_r));

    assign cur_is_err_s = (cur_id_r == ERR_ID);

    // Pick the grant of the addressed target and the response of the current target.
    always_comb begin
        sel_gnt_s    = 1'b0;
        sel_rvalid_s = 1'b0;
        sel_rdata_s  = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_TARGETS; k++) begin
            sel_gnt_s    = sel_gnt_s | (tgt_gnt_i[k] & (id_s == ID_W'(k)));
            sel_rvalid_s = sel_rvalid_s | (tgt_rvalid_i[k] & (cur_id_r == ID_W'(k)));
            sel_rdata_s  = sel_rdata_s
                         | (tgt_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]
                            & {DATA_WIDTH{cur_id_r == ID_W'(k)}});
        end
    end

    // Forward the request to the addressed target unless stalled.
    always_comb begin
        tgt_req_o = {NUM_TARGETS{1'b0}};
        for (int k = 0; k < NUM_TARGETS; k++) begin
            tgt_req_o[k] = init_req_i & ~stall_s & (id_s == ID_W'(k));
        end
    end

    // Unmapped requests are granted at once; the error responder always accepts.
    assign init_gnt_o = init_req_i & ~stall_s & (unmapped_s | sel_gnt_s);
    assign accept_s   = init_req_i & init_gnt_o;

    obi_err_responder #(
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_RDATA  (ERR_RDATA)
    ) u_err_responder (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .accept_i (accept_s & unmapped_s),
        .rvalid_o (err_rvalid_s),
        .rdata_o  (err_rdata_s)
    );

    // A response counts only from the current target while transactions are in flight.
    assign fwd_rsp_s   = (state_r == ACTIVE) & (count_r != CNT_ZERO)
                       & (cur_is_err_s ? err_rvalid_s : sel_rvalid_s);
    assign flush_rsp_s = (state_r == FLUSH);
    assign timeout_s   = (state_r == ACTIVE) & ~fwd_rsp_s & (timer_r == TMR_LAST);
    assign timeout_o   = timeout_s;

    // Response mux towards the initiator: flush errors, then forwarded responses.
    always_comb begin
        init_rvalid_o = 1'b0;
        init_err_o    = 1'b0;
        init_rdata_o  = {DATA_WIDTH{1'b0}};
        if (flush_rsp_s) begin
            init_rvalid_o = 1'b1;
            init_err_o    = 1'b1;
            init_rdata_o  = ERR_RDATA;
        end else if (fwd_rsp_s) begin
            init_rvalid_o = 1'b1;
            init_err_o    = cur_is_err_s;
            init_rdata_o  = cur_is_err_s ? err_rdata_s : sel_rdata_s;
        end else begin
            init_rvalid_o = 1'b0;
        end
    end

    // Next-state logic for the control FSM, outstanding counter and response timer.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        timer_nxt_s = timer_r;
        case (state_r)
            IDLE: begin
                timer_nxt_s = TMR_ZERO;
                if (accept_s) begin
                    state_nxt_s = ACTIVE;
                    count_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE;
                    count_nxt_s = CNT_ZERO;
                end
            end
            ACTIVE: begin
                if (accept_s && !fwd_rsp_s) begin
                    count_nxt_s = count_r + CNT_ONE;
                end else if (!accept_s && fwd_rsp_s) begin
                    count_nxt_s = count_r - CNT_ONE;
                end else begin
                    count_nxt_s = count_r;
                end
                if (fwd_rsp_s) begin
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
                if (count_nxt_s == CNT_ZERO) begin
                    state_nxt_s = IDLE;
                end else if (timeout_s) begin
                    state_nxt_s = FLUSH;
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            FLUSH: begin
                timer_nxt_s = TMR_ZERO;
                if (count_r <= CNT_ONE) begin
                    state_nxt_s = IDLE;
                    count_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = FLUSH;
                    count_nxt_s = count_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                count_nxt_s = CNT_ZERO;
                timer_nxt_s = TMR_ZERO;
            end
        endcase
    end

    // Control state registers; cur_id follows the most recently accepted target.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            count_r  <= CNT_ZERO;
            timer_r  <= TMR_ZERO;
            cur_id_r <= {ID_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            timer_r  <= timer_nxt_s;
            cur_id_r <= accept_s ? id_s : cur_id_r;
        end
    end

endmodule

// File: tb/tb_obi_periph_demux.sv
// Scoreboard bench for obi_periph_demux with randomized traffic, behavioural
// target models and a transaction-level reference of the demux rules.
module tb_obi_periph_demux;

    localparam int NT   = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;
    localparam int TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_req, init_we, init_gnt, init_rvalid, init_err, timeout;
    logic [AW-1:0]     init_addr, tgt_addr;
    logic [DW/8-1:0]   init_be, tgt_be;
    logic [DW-1:0]     init_wdata, init_rdata, tgt_wdata;
    logic [NT-1:0]     tgt_req, tgt_gnt, tgt_rvalid;
    logic              tgt_we;
    logic [NT*DW-1:0]  tgt_rdata;

    obi_periph_demux #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TARGETS(NT), .SEL_LSB(20), .SEL_WIDTH(2),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERRD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .init_req_i(init_req), .init_gnt_o(init_gnt), .init_addr_i(init_addr),
        .init_we_i(init_we), .init_be_i(init_be), .init_wdata_i(init_wdata),
        .init_rvalid_o(init_rvalid), .init_rdata_o(init_rdata), .init_err_o(init_err),
        .tgt_req_o(tgt_req), .tgt_gnt_i(tgt_gnt), .tgt_addr_o(tgt_addr), .tgt_we_o(tgt_we),
        .tgt_be_o(tgt_be), .tgt_wdata_o(tgt_wdata), .tgt_rvalid_i(tgt_rvalid),
        .tgt_rdata_i(tgt_rdata), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct { logic err; logic [31:0] data; } rsp_t;
    typedef struct { int tgt; logic [31:0] data; int due; } tx_t;

    int   n_chk = 0, n_pass = 0, cyc = 0, to_cnt = 0;
    int   outq[$];          // reference: target id of every outstanding transaction, oldest first
    rsp_t expq[$];          // scoreboard: expected responses in order
    tx_t  tgtq[$];          // bench targets: accepted reads awaiting their reply
    bit   flushing = 0, gnt_all = 1, inject_en = 0, fix_data_en = 0, drove_real = 0;
    int   wait_cnt = 0, mute = -1, fix_lat = 0, sk;
    logic [31:0] fix_data = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Bench targets: random grants, in-order replies after their latency, stray rvalids.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (drove_real && tgtq.size() > 0) void'(tgtq.pop_front());
        #1;
        drove_real = 0;
        tgt_rvalid = '0;
        tgt_rdata  = '0;
        for (int k = 0; k < NT; k++) tgt_gnt[k] = gnt_all || ($urandom_range(3, 0) != 0);
        if (rst_n) begin
            if (tgtq.size() > 0 && tgtq[0].due <= cyc) begin
                tgt_rvalid[tgtq[0].tgt] = 1'b1;
                tgt_rdata[tgtq[0].tgt*DW +: DW] = tgtq[0].data;
                drove_real = 1;
            end
            if (inject_en && $urandom_range(7, 0) == 0) begin
                sk = $urandom_range(NT - 1, 0);
                if ((outq.size() == 0 || outq[0] != sk) && !tgt_rvalid[sk]) begin
                    tgt_rvalid[sk] = 1'b1;
                    tgt_rdata[sk*DW +: DW] = $urandom;
                end
            end
        end
    end

    int          m_id, m_lat;
    bit          m_unm, m_stall, m_rsp, m_gnt, m_to;
    logic [NT-1:0] m_req;
    logic [31:0] m_d;

    // Reference model: predicts grant, forwarding, response timing and timeout each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            m_id  = int'(init_addr[21:20]);
            m_unm = (m_id >= NT);
            if (flushing) m_rsp = 1;
            else if (outq.size() == 0) m_rsp = 0;
            else if (outq[0] == NT) m_rsp = 1;
            else m_rsp = tgt_rvalid[outq[0]];
            m_stall = flushing || outq.size() == MAXO || (outq.size() > 0 && outq[$] != m_id);
            m_gnt   = init_req && !m_stall && (m_unm || tgt_gnt[m_id]);
            m_req   = '0;
            if (init_req && !m_stall && !m_unm) m_req[m_id] = 1'b1;
            m_to = !flushing && outq.size() > 0 && !m_rsp && wait_cnt == TMO - 1;
            chk("init_gnt", init_gnt, m_gnt);
            chk("tgt_req", tgt_req, m_req);
            chk("init_rvalid", init_rvalid, m_rsp);
            chk("timeout", timeout, m_to);
            chk("bcast", {tgt_addr, tgt_we, tgt_be}, {init_addr, init_we, init_be});
            chk("bcast_wdata", tgt_wdata, init_wdata);
            if (timeout) to_cnt++;
            if (m_rsp) begin
                void'(outq.pop_front());
                wait_cnt = 0;
                if (outq.size() == 0) flushing = 0;
            end else if (outq.size() > 0 && !flushing) begin
                wait_cnt++;
            end
            if (m_to) flushing = 1;
            if (m_gnt) begin
                if (outq.size() == 0) wait_cnt = 0;
                outq.push_back(m_unm ? NT : m_id);
                if (m_unm || m_id == mute) begin
                    expq.push_back('{1'b1, ERRD});
                end else begin
                    m_d   = fix_data_en ? fix_data : $urandom;
                    m_lat = (fix_lat != 0) ? fix_lat : $urandom_range(4, 1);
                    expq.push_back('{1'b0, m_d});
                    tgtq.push_back('{m_id, m_d, cyc + m_lat});
                end
            end
        end
    end

    rsp_t mon_e;
    // Monitor: every response the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && init_rvalid) begin
            chk("rsp_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("rsp_err", init_err, mon_e.err);
                chk("rsp_rdata", init_rdata, mon_e.data);
            end
        end
    end

    // Present one request and hold it until granted (bounded).
    task automatic issue(input logic [31:0] addr);
        bit done = 0;
        int n = 0;
        init_req = 1'b1; init_addr = addr; init_we = $urandom_range(1, 0);
        init_be = $urandom; init_wdata = $urandom;
        while (!done && n < 100) begin
            @(negedge clk);
            done = init_gnt;
            n++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("gnt_bound", done, 1);
        init_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] ra;
    initial begin
        init_req = 0; init_addr = '0; init_we = 0; init_be = '0; init_wdata = '0;
        tgt_gnt = '0; tgt_rvalid = '0; tgt_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", init_rvalid, 0); chk("rst_err", init_err, 0);
        chk("rst_rdata", init_rdata, 0);   chk("rst_timeout", timeout, 0);
        chk("rst_gnt", init_gnt, 0);       chk("rst_tgt_req", tgt_req, 0);
        rst_n = 1'b1;

        // Read to target 1, reply two cycles after the grant.
        fix_data_en = 1; fix_data = 32'h1234_5678; fix_lat = 2;
        issue(32'h0010_0004);
        idle(4);
        fix_data_en = 0; fix_lat = 0;

        // Unmapped accesses, back to back.
        issue(32'h0030_0000);
        issue(32'h0030_0040);
        idle(3);

        // Target 2 hangs on two reads; a target 0 read waits behind the flush.
        mute = 2;
        issue(32'h0020_0000);
        issue(32'h0020_0010);
        issue(32'h0000_0020);
        mute = -1;
        idle(8);
        chk("timeout_pulses", to_cnt, 1);

        // Asynchronous reset with two reads in flight.
        mute = 1;
        issue(32'h0010_0000);
        issue(32'h0010_0008);
        idle(2);
        #3;
        rst_n = 1'b0;
        outq.delete(); expq.delete(); tgtq.delete();
        flushing = 0; wait_cnt = 0; mute = -1;
        #1;
        chk("arst_rvalid", init_rvalid, 0); chk("arst_err", init_err, 0);
        chk("arst_rdata", init_rdata, 0);   chk("arst_timeout", timeout, 0);
        chk("arst_gnt", init_gnt, 0);       chk("arst_tgt_req", tgt_req, 0);
        idle(2);
        rst_n = 1'b1;
        issue(32'h0000_0010);
        idle(5);

        // Randomized traffic with random grants, latencies and stray responses.
        gnt_all = 0; inject_en = 1;
        for (int t = 0; t < 300; t++) begin
            ra = $urandom;
            ra[21:20] = ($urandom_range(5, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
            issue(ra);
            if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 1));
        end
        inject_en = 0;
        for (int n = 0; n < 100 && expq.size() > 0; n++) idle(1);
        chk("drain", expq.size(), 0);
        chk("timeout_pulses_end", to_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
